// File: rtl/hdc_multimode_ctrl.sv
// -----------------------------------------------------------------------------
// hdc_multimode_ctrl
//
// Sequences the HDC mapping, encoding, class-HV-generation and associative
// memory blocks through three phases: training, optional iterative retraining
// epochs, and testing. Samples are accepted one at a time over a valid/ready
// handshake. Exactly one sample is in flight between acceptance and the
// matching encoding_done / inference_valid pulse.
//
// During retraining every misclassified sample produces a one-cycle
// update_valid pulse naming the class to add to (true label) and the class to
// subtract from (wrong inference). Retraining stops after num_epochs epochs,
// or earlier when an epoch finishes with no misclassifications.
//
// Ports
//   clk, nrst             clock, asynchronous active-low reset
//   en                    clock enable; all state and outputs hold when 0
//   start, mode,          run control (sampled in IDLE/DONE); mode 00 train+test,
//   num_epochs            01 train+retrain+test, 10 test only, 11 ignored
//   sample_valid/label/   upstream sample handshake; sample_ready is high in
//   last, sample_ready    the TRAIN/RETRAIN/TEST sample states
//   start_mapping         pulse, cycle after a sample is accepted
//   encoding_done,        completion pulses from the encoder, associative
//   inference_valid,      memory and class-HV generator
//   class_inference,
//   class_gen_done
//   *_hdc_model           phase flags (training / retraining / testing)
//   train_label           label of the in-flight sample
//   finalize_class_gen    pulse requesting class-HV binarisation
//   update_*              class update command for misclassified retrain samples
//   epoch_index,          retrain epoch and its correct-inference count
//   epoch_correct_count
//   correct_count         correct inferences in the test phase
//   busy, done            run status
// -----------------------------------------------------------------------------
module hdc_multimode_ctrl #(
  parameter int CLASS_COUNT = 26,
  parameter int CLASS_W     = 5,
  parameter int EPOCH_W     = 4,
  parameter int CNT_W       = 11
) (
  input  logic               clk,
  input  logic               nrst,
  input  logic               en,
  input  logic               start,
  input  logic [1:0]         mode,
  input  logic [EPOCH_W-1:0] num_epochs,
  input  logic               sample_valid,
  input  logic [CLASS_W-1:0] sample_label,
  input  logic               sample_last,
  output logic               sample_ready,
  output logic               start_mapping,
  input  logic               encoding_done,
  input  logic               inference_valid,
  input  logic [CLASS_W-1:0] class_inference,
  input  logic               class_gen_done,
  output logic               training_hdc_model,
  output logic               retraining_hdc_model,
  output logic               testing_hdc_model,
  output logic [CLASS_W-1:0] train_label,
  output logic               finalize_class_gen,
  output logic               update_valid,
  output logic [CLASS_W-1:0] update_add_class,
  output logic [CLASS_W-1:0] update_sub_class,
  output logic [EPOCH_W-1:0] epoch_index,
  output logic [CNT_W-1:0]   epoch_correct_count,
  output logic [CNT_W-1:0]   correct_count,
  output logic               busy,
  output logic               done
);

  if ((1 << CLASS_W) < CLASS_COUNT) begin : g_class_w_check
    $error("hdc_multimode_ctrl: CLASS_W too narrow for CLASS_COUNT");
  end

  localparam logic [1:0] MODE_TRAIN_TEST   = 2'b00;
  localparam logic [1:0] MODE_TRAIN_RETRAIN = 2'b01;
  localparam logic [1:0] MODE_TEST_ONLY    = 2'b10;
  localparam logic [1:0] MODE_RESERVED     = 2'b11;

  typedef enum logic [3:0] {
    S_IDLE,
    S_TRAIN,
    S_TRAIN_WAIT,
    S_TGEN,
    S_RETRAIN,
    S_RETRAIN_WAIT,
    S_RGEN,
    S_TEST,
    S_TEST_WAIT,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_next_state;

  // Run configuration latched at start
  logic [1:0]         r_mode;
  logic [EPOCH_W-1:0] r_num_epochs;

  // In-flight sample
  logic [CLASS_W-1:0] r_train_label;
  logic               r_last;

  // Epoch bookkeeping
  logic [EPOCH_W-1:0] r_epoch_index;
  logic [CNT_W-1:0]   r_epoch_correct;
  logic               r_epoch_miss;
  logic [CNT_W-1:0]   r_correct;

  // Registered one-cycle pulses and the update command
  logic               r_start_mapping;
  logic               r_finalize;
  logic               r_update_valid;
  logic [CLASS_W-1:0] r_update_add;
  logic [CLASS_W-1:0] r_update_sub;

  // Control strobes from the next-state logic
  logic w_start_run;
  logic w_accept;
  logic w_finalize;
  logic w_epoch_hit;
  logic w_epoch_miss;
  logic w_test_hit;
  logic w_next_epoch;
  logic w_sample_state;
  logic w_match;
  logic w_last_epoch;

  assign w_sample_state = (r_state == S_TRAIN) || (r_state == S_RETRAIN) ||
                          (r_state == S_TEST);
  assign w_match        = (class_inference == r_train_label);
  assign w_last_epoch   = (({1'b0, r_epoch_index} + 1'b1) == {1'b0, r_num_epochs});

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of block order.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state <= S_IDLE;
    end else if (en) begin
      r_state <= w_next_state;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and control strobes
  // ---------------------------------------------------------------------------
  // NOTE: every signal written here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    w_next_state = r_state;
    w_start_run  = 1'b0;
    w_accept     = 1'b0;
    w_finalize   = 1'b0;
    w_epoch_hit  = 1'b0;
    w_epoch_miss = 1'b0;
    w_test_hit   = 1'b0;
    w_next_epoch = 1'b0;

    case (r_state)
      // DONE accepts a new start exactly like IDLE
      S_IDLE, S_DONE: begin
        if (start && (mode != MODE_RESERVED)) begin
          w_start_run  = 1'b1;
          w_next_state = (mode == MODE_TEST_ONLY) ? S_TEST : S_TRAIN;
        end
      end

      S_TRAIN: begin
        if (sample_valid) begin
          w_accept     = 1'b1;
          w_next_state = S_TRAIN_WAIT;
        end
      end

      S_TRAIN_WAIT: begin
        if (encoding_done) begin
          if (r_last) begin
            w_finalize   = 1'b1;
            w_next_state = S_TGEN;
          end else begin
            w_next_state = S_TRAIN;
          end
        end
      end

      S_TGEN: begin
        if (class_gen_done) begin
          if ((r_mode == MODE_TRAIN_RETRAIN) && (r_num_epochs != '0)) begin
            w_next_state = S_RETRAIN;
          end else begin
            w_next_state = S_TEST;
          end
        end
      end

      S_RETRAIN: begin
        if (sample_valid) begin
          w_accept     = 1'b1;
          w_next_state = S_RETRAIN_WAIT;
        end
      end

      S_RETRAIN_WAIT: begin
        if (inference_valid) begin
          w_epoch_hit  = w_match;
          w_epoch_miss = !w_match;
          if (r_last) begin
            w_finalize   = 1'b1;
            w_next_state = S_RGEN;
          end else begin
            w_next_state = S_RETRAIN;
          end
        end
      end

      // Leave retraining on the epoch limit or after a clean epoch
      S_RGEN: begin
        if (class_gen_done) begin
          if (w_last_epoch || !r_epoch_miss) begin
            w_next_state = S_TEST;
          end else begin
            w_next_epoch = 1'b1;
            w_next_state = S_RETRAIN;
          end
        end
      end

      S_TEST: begin
        if (sample_valid) begin
          w_accept     = 1'b1;
          w_next_state = S_TEST_WAIT;
        end
      end

      S_TEST_WAIT: begin
        if (inference_valid) begin
          w_test_hit   = w_match;
          w_next_state = r_last ? S_DONE : S_TEST;
        end
      end

      default: w_next_state = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_mode          <= '0;
      r_num_epochs    <= '0;
      r_train_label   <= '0;
      r_last          <= 1'b0;
      r_epoch_index   <= '0;
      r_epoch_correct <= '0;
      r_epoch_miss    <= 1'b0;
      r_correct       <= '0;
      r_start_mapping <= 1'b0;
      r_finalize      <= 1'b0;
      r_update_valid  <= 1'b0;
      r_update_add    <= '0;
      r_update_sub    <= '0;
    end else if (en) begin
      r_start_mapping <= w_accept;
      r_finalize      <= w_finalize;
      r_update_valid  <= w_epoch_miss;

      if (w_start_run) begin
        r_mode          <= mode;
        r_num_epochs    <= num_epochs;
        r_epoch_index   <= '0;
        r_epoch_correct <= '0;
        r_epoch_miss    <= 1'b0;
        r_correct       <= '0;
      end

      if (w_accept) begin
        r_train_label <= sample_label;
        r_last        <= sample_last;
      end

      // Counters saturate at all-ones instead of wrapping
      if (w_epoch_hit && (r_epoch_correct != '1)) begin
        r_epoch_correct <= r_epoch_correct + 1'b1;
      end

      if (w_epoch_miss) begin
        r_epoch_miss <= 1'b1;
        r_update_add <= r_train_label;
        r_update_sub <= class_inference;
      end

      if (w_test_hit && (r_correct != '1)) begin
        r_correct <= r_correct + 1'b1;
      end

      if (w_next_epoch) begin
        r_epoch_index   <= r_epoch_index + 1'b1;
        r_epoch_correct <= '0;
        r_epoch_miss    <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  // A pulse scheduled just before en drops stays pending in its register and
  // is shown only once en returns, so no pulse fires while the system is held.
  assign start_mapping        = r_start_mapping & en;
  assign finalize_class_gen   = r_finalize & en;
  assign update_valid         = r_update_valid & en;

  assign sample_ready         = w_sample_state;
  assign training_hdc_model   = (r_state == S_TRAIN) || (r_state == S_TRAIN_WAIT) ||
                                (r_state == S_TGEN);
  assign retraining_hdc_model = (r_state == S_RETRAIN) || (r_state == S_RETRAIN_WAIT) ||
                                (r_state == S_RGEN);
  assign testing_hdc_model    = (r_state == S_TEST) || (r_state == S_TEST_WAIT);
  assign busy                 = (r_state != S_IDLE) && (r_state != S_DONE);
  assign done                 = (r_state == S_DONE);

  assign train_label          = r_train_label;
  assign update_add_class     = r_update_add;
  assign update_sub_class     = r_update_sub;
  assign epoch_index          = r_epoch_index;
  assign epoch_correct_count  = r_epoch_correct;
  assign correct_count        = r_correct;

  // Mode encoding 00 needs no special handling beyond "not retrain"
  logic w_unused_mode;
  assign w_unused_mode = (r_mode == MODE_TRAIN_TEST);

endmodule

// File: tb/tb_hdc_multimode_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hdc_multimode_ctrl
//
// Self-checking bench for hdc_multimode_ctrl. The bench plays the part of the
// mapping/encoder/associative-memory/class-generator blocks. A dataset-level
// reference model (per-epoch loops over label/inference tables) predicts the
// number of mapping and finalize pulses, the list of class updates, the number
// of retrain epochs and the final counters. A second instance with CNT_W = 2
// shares all inputs and exercises counter saturation.
// -----------------------------------------------------------------------------
module tb_hdc_multimode_ctrl;

  localparam int CW = 5;
  localparam int EW = 4;
  localparam int NW = 11;
  localparam int SW = 2;

  logic          clk = 1'b0;
  logic          nrst;
  logic          en;
  logic          start;
  logic [1:0]    mode;
  logic [EW-1:0] num_epochs;
  logic          sample_valid;
  logic [CW-1:0] sample_label;
  logic          sample_last;
  logic          encoding_done;
  logic          inference_valid;
  logic [CW-1:0] class_inference;
  logic          class_gen_done;

  logic          sample_ready, start_mapping, finalize_class_gen, update_valid;
  logic          training_hdc_model, retraining_hdc_model, testing_hdc_model;
  logic [CW-1:0] train_label, update_add_class, update_sub_class;
  logic [EW-1:0] epoch_index;
  logic [NW-1:0] epoch_correct_count, correct_count;
  logic          busy, done;

  logic          s_sample_ready, s_start_mapping, s_finalize, s_update_valid;
  logic          s_training, s_retraining, s_testing;
  logic [CW-1:0] s_train_label, s_update_add, s_update_sub;
  logic [EW-1:0] s_epoch_index;
  logic [SW-1:0] s_epoch_correct, s_correct;
  logic          s_busy, s_done;

  hdc_multimode_ctrl dut (
    .clk(clk), .nrst(nrst), .en(en), .start(start), .mode(mode),
    .num_epochs(num_epochs), .sample_valid(sample_valid),
    .sample_label(sample_label), .sample_last(sample_last),
    .sample_ready(sample_ready), .start_mapping(start_mapping),
    .encoding_done(encoding_done), .inference_valid(inference_valid),
    .class_inference(class_inference), .class_gen_done(class_gen_done),
    .training_hdc_model(training_hdc_model),
    .retraining_hdc_model(retraining_hdc_model),
    .testing_hdc_model(testing_hdc_model), .train_label(train_label),
    .finalize_class_gen(finalize_class_gen), .update_valid(update_valid),
    .update_add_class(update_add_class), .update_sub_class(update_sub_class),
    .epoch_index(epoch_index), .epoch_correct_count(epoch_correct_count),
    .correct_count(correct_count), .busy(busy), .done(done)
  );

  hdc_multimode_ctrl #(.CNT_W(SW)) dut_sat (
    .clk(clk), .nrst(nrst), .en(en), .start(start), .mode(mode),
    .num_epochs(num_epochs), .sample_valid(sample_valid),
    .sample_label(sample_label), .sample_last(sample_last),
    .sample_ready(s_sample_ready), .start_mapping(s_start_mapping),
    .encoding_done(encoding_done), .inference_valid(inference_valid),
    .class_inference(class_inference), .class_gen_done(class_gen_done),
    .training_hdc_model(s_training), .retraining_hdc_model(s_retraining),
    .testing_hdc_model(s_testing), .train_label(s_train_label),
    .finalize_class_gen(s_finalize), .update_valid(s_update_valid),
    .update_add_class(s_update_add), .update_sub_class(s_update_sub),
    .epoch_index(s_epoch_index), .epoch_correct_count(s_epoch_correct),
    .correct_count(s_correct), .busy(s_busy), .done(s_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Pulse monitors, sampled on the falling edge
  int          n_sm  = 0;
  int          n_fin = 0;
  logic [9:0]  upd_q[$];

  always @(negedge clk) begin
    if (start_mapping === 1'b1) n_sm++;
    if (finalize_class_gen === 1'b1) n_fin++;
    if (update_valid === 1'b1) upd_q.push_back({update_add_class, update_sub_class});
  end

  // Dataset tables used by run_flow
  int lbl_tr[8];
  int inf_ep[8][8];
  int lbl_te[8];
  int inf_te[8];

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  function automatic logic [49:0] all_outputs();
    return {sample_ready, start_mapping, training_hdc_model, retraining_hdc_model,
            testing_hdc_model, train_label, finalize_class_gen, update_valid,
            update_add_class, update_sub_class, epoch_index, epoch_correct_count,
            correct_count, busy, done};
  endfunction

  // One sample through the handshake; either encoding_done or inference_valid
  // answers it.
  task automatic do_sample(input int lbl, input bit last, input bit use_inf, input int inf);
    for (int k = 0; k < 20 && sample_ready !== 1'b1; k++) @(negedge clk);
    checks++;
    if (sample_ready !== 1'b1) begin
      errors++;
      $display("FAIL sample_ready_timeout: got %b expected 1", sample_ready);
    end
    sample_valid = 1'b1;
    sample_label = lbl[CW-1:0];
    sample_last  = last;
    @(negedge clk);
    sample_valid = 1'b0;
    sample_last  = 1'b0;
    checks++;
    if (start_mapping !== 1'b1 || sample_ready !== 1'b0 || train_label !== lbl[CW-1:0]) begin
      errors++;
      $display("FAIL accept: start_mapping=%b ready=%b label=%0d expected 1/0/%0d",
               start_mapping, sample_ready, train_label, lbl);
    end
    if (use_inf) begin
      inference_valid = 1'b1;
      class_inference = inf[CW-1:0];
    end else begin
      encoding_done = 1'b1;
    end
    @(negedge clk);
    inference_valid = 1'b0;
    encoding_done   = 1'b0;
  endtask

  task automatic gen_pulse();
    class_gen_done = 1'b1;
    @(negedge clk);
    class_gen_done = 1'b0;
  endtask

  // Full run from IDLE/DONE against the dataset tables
  task automatic run_flow(input int md, input int ne, input int ntr, input int nte, input string tag);
    int         base_sm, base_fin, base_q;
    int         exp_sm, exp_fin, n_ep, exp_test, cnt;
    bit         miss;
    int         ep_cnt[8];
    logic [9:0] exp_upd[$];

    base_sm  = n_sm;
    base_fin = n_fin;
    base_q   = upd_q.size();

    // Reference model
    exp_sm = 0; exp_fin = 0; n_ep = 0; exp_test = 0;
    if (md != 2) begin
      exp_sm += ntr;
      exp_fin++;
    end
    if (md == 1 && ne != 0) begin
      for (int e = 0; e < 8; e++) begin
        miss = 0; cnt = 0;
        for (int i = 0; i < ntr; i++) begin
          if (inf_ep[e][i] == lbl_tr[i]) cnt++;
          else begin
            miss = 1;
            exp_upd.push_back({lbl_tr[i][4:0], inf_ep[e][i][4:0]});
          end
        end
        ep_cnt[e] = cnt;
        exp_sm += ntr;
        exp_fin++;
        n_ep = e + 1;
        if (e + 1 == ne || !miss) break;
      end
    end
    for (int i = 0; i < nte; i++) if (inf_te[i] == lbl_te[i]) exp_test++;
    exp_sm += nte;

    // Start
    mode       = md[1:0];
    num_epochs = ne[EW-1:0];
    start      = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (busy !== 1'b1 || (md == 2 ? testing_hdc_model : training_hdc_model) !== 1'b1) begin
      errors++;
      $display("FAIL %s start_phase: busy=%b train=%b test=%b", tag, busy,
               training_hdc_model, testing_hdc_model);
    end

    // Training pass
    if (md != 2) begin
      for (int i = 0; i < ntr; i++) do_sample(lbl_tr[i], i == ntr - 1, 1'b0, 0);
      checks++;
      if (training_hdc_model !== 1'b1 || sample_ready !== 1'b0) begin
        errors++;
        $display("FAIL %s tgen: train=%b ready=%b expected 1/0", tag, training_hdc_model, sample_ready);
      end
      gen_pulse();
      checks++;
      if ((n_ep > 0 ? retraining_hdc_model : testing_hdc_model) !== 1'b1) begin
        errors++;
        $display("FAIL %s after_tgen: retrain=%b test=%b epochs=%0d", tag,
                 retraining_hdc_model, testing_hdc_model, n_ep);
      end
    end

    // Retraining epochs
    for (int e = 0; e < n_ep; e++) begin
      checks++;
      if (epoch_index !== EW'(e) || epoch_correct_count !== '0) begin
        errors++;
        $display("FAIL %s epoch_start: index=%0d count=%0d expected %0d/0", tag,
                 epoch_index, epoch_correct_count, e);
      end
      for (int i = 0; i < ntr; i++) do_sample(lbl_tr[i], i == ntr - 1, 1'b1, inf_ep[e][i]);
      checks++;
      if (epoch_correct_count !== NW'(ep_cnt[e]) || s_epoch_correct !== SW'(sat(ep_cnt[e], 3))) begin
        errors++;
        $display("FAIL %s epoch_count: got %0d/%0d expected %0d/%0d", tag, epoch_correct_count,
                 s_epoch_correct, ep_cnt[e], sat(ep_cnt[e], 3));
      end
      gen_pulse();
      checks++;
      if ((e < n_ep - 1 ? retraining_hdc_model : testing_hdc_model) !== 1'b1) begin
        errors++;
        $display("FAIL %s after_rgen: retrain=%b test=%b epoch=%0d", tag,
                 retraining_hdc_model, testing_hdc_model, e);
      end
    end

    // Test pass
    for (int i = 0; i < nte; i++) do_sample(lbl_te[i], i == nte - 1, 1'b1, inf_te[i]);
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || testing_hdc_model !== 1'b0) begin
      errors++;
      $display("FAIL %s done: done=%b busy=%b test=%b expected 1/0/0", tag, done, busy, testing_hdc_model);
    end
    checks++;
    if (correct_count !== NW'(sat(exp_test, 2047)) || s_correct !== SW'(sat(exp_test, 3))) begin
      errors++;
      $display("FAIL %s correct_count: got %0d/%0d expected %0d/%0d", tag, correct_count,
               s_correct, exp_test, sat(exp_test, 3));
    end
    checks++;
    if (n_ep > 0) begin
      if (epoch_index !== EW'(n_ep - 1) || epoch_correct_count !== NW'(ep_cnt[n_ep - 1])) begin
        errors++;
        $display("FAIL %s final_epoch: index=%0d count=%0d expected %0d/%0d", tag,
                 epoch_index, epoch_correct_count, n_ep - 1, ep_cnt[n_ep - 1]);
      end
    end else if (epoch_index !== '0 || epoch_correct_count !== '0) begin
      errors++;
      $display("FAIL %s final_epoch: index=%0d count=%0d expected 0/0", tag,
               epoch_index, epoch_correct_count);
    end

    @(negedge clk);
    checks++;
    if (n_sm - base_sm != exp_sm || n_fin - base_fin != exp_fin) begin
      errors++;
      $display("FAIL %s pulse_counts: mapping=%0d finalize=%0d expected %0d/%0d", tag,
               n_sm - base_sm, n_fin - base_fin, exp_sm, exp_fin);
    end
    checks++;
    if (upd_q.size() - base_q != exp_upd.size()) begin
      errors++;
      $display("FAIL %s update_count: got %0d expected %0d", tag, upd_q.size() - base_q, exp_upd.size());
    end else begin
      for (int i = 0; i < exp_upd.size(); i++) begin
        checks++;
        if (upd_q[base_q + i] !== exp_upd[i]) begin
          errors++;
          $display("FAIL %s update_%0d: add/sub=%0d/%0d expected %0d/%0d", tag, i,
                   upd_q[base_q + i][9:5], upd_q[base_q + i][4:0], exp_upd[i][9:5], exp_upd[i][4:0]);
        end
      end
    end
  endtask

  // --------------------------------------------------------------------------
  task automatic test_reset();
    nrst = 1'b0;
    #1;
    checks++;
    if (all_outputs() !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got %h expected 0", all_outputs());
    end
    repeat (2) @(negedge clk);
    nrst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reserved_mode();
    mode = 2'b11;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || training_hdc_model !== 1'b0 || testing_hdc_model !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reserved_mode: busy=%b train=%b test=%b done=%b expected all 0",
               busy, training_hdc_model, testing_hdc_model, done);
    end
  endtask

  task automatic test_train_test();
    lbl_tr[0] = 2; lbl_tr[1] = 9; lbl_tr[2] = 17;
    lbl_te[0] = 4; inf_te[0] = 4;
    lbl_te[1] = 7; inf_te[1] = 2;
    run_flow(0, 0, 3, 2, "train_test");
  endtask

  task automatic test_retrain();
    lbl_tr[0] = 1; lbl_tr[1] = 3;
    inf_ep[0][0] = 1; inf_ep[0][1] = 5;
    inf_ep[1][0] = 1; inf_ep[1][1] = 3;
    lbl_te[0] = 3; inf_te[0] = 3;
    lbl_te[1] = 1; inf_te[1] = 1;
    run_flow(1, 2, 2, 2, "retrain");
  endtask

  task automatic test_early_exit();
    lbl_tr[0] = 6; lbl_tr[1] = 25; lbl_tr[2] = 0;
    for (int i = 0; i < 3; i++) inf_ep[0][i] = lbl_tr[i];
    lbl_te[0] = 12; inf_te[0] = 11;
    run_flow(1, 5, 3, 1, "early_exit");
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 5; i++) begin
      lbl_te[i] = i + 10;
      inf_te[i] = i + 10;
    end
    run_flow(2, 0, 0, 5, "saturation");
  endtask

  task automatic test_random();
    int md, ne, ntr, nte;
    for (int r = 0; r < 8; r++) begin
      md  = $urandom_range(0, 2);
      ne  = $urandom_range(0, 4);
      ntr = $urandom_range(1, 6);
      nte = $urandom_range(1, 6);
      for (int i = 0; i < ntr; i++) lbl_tr[i] = $urandom_range(0, 25);
      for (int e = 0; e < 8; e++)
        for (int i = 0; i < ntr; i++)
          inf_ep[e][i] = ($urandom_range(0, 9) < 7) ? lbl_tr[i] : $urandom_range(0, 25);
      for (int i = 0; i < nte; i++) begin
        lbl_te[i] = $urandom_range(0, 25);
        inf_te[i] = ($urandom_range(0, 9) < 6) ? lbl_te[i] : $urandom_range(0, 25);
      end
      run_flow(md, ne, ntr, nte, $sformatf("random_%0d", r));
    end
  endtask

  task automatic test_enable_hold();
    logic [CW-1:0] old_label;
    int            base_sm;
    mode = 2'b10;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    old_label = train_label;
    base_sm = n_sm;
    en = 1'b0;
    sample_valid = 1'b1;
    sample_label = 5'd9;
    repeat (3) @(negedge clk);
    checks++;
    if (n_sm != base_sm || train_label !== old_label || testing_hdc_model !== 1'b1) begin
      errors++;
      $display("FAIL enable_hold: mapping=%0d label=%0d test=%b expected %0d/%0d/1",
               n_sm, train_label, testing_hdc_model, base_sm, old_label);
    end
    en = 1'b1;
    @(negedge clk);
    sample_valid = 1'b0;
    checks++;
    if (start_mapping !== 1'b1 || train_label !== 5'd9) begin
      errors++;
      $display("FAIL enable_resume: start_mapping=%b label=%0d expected 1/9", start_mapping, train_label);
    end
    // An inference pulse while en=0 is lost
    en = 1'b0;
    inference_valid = 1'b1;
    class_inference = 5'd9;
    @(negedge clk);
    inference_valid = 1'b0;
    en = 1'b1;
    @(negedge clk);
    checks++;
    if (correct_count !== '0 || sample_ready !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL enable_lost_pulse: count=%0d ready=%b busy=%b expected 0/0/1",
               correct_count, sample_ready, busy);
    end
    inference_valid = 1'b1;
    @(negedge clk);
    inference_valid = 1'b0;
    do_sample(3, 1'b1, 1'b1, 3);
    checks++;
    if (done !== 1'b1 || correct_count !== NW'(2)) begin
      errors++;
      $display("FAIL enable_finish: done=%b count=%0d expected 1/2", done, correct_count);
    end
  endtask

  task automatic test_reset_midrun();
    int base_q;
    mode = 2'b01;
    num_epochs = 4'd3;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    do_sample(8, 1'b1, 1'b0, 0);
    gen_pulse();
    sample_valid = 1'b1;
    sample_label = 5'd8;
    @(negedge clk);
    sample_valid = 1'b0;
    checks++;
    if (retraining_hdc_model !== 1'b1 || sample_ready !== 1'b0) begin
      errors++;
      $display("FAIL retrain_wait_entry: retrain=%b ready=%b expected 1/0", retraining_hdc_model, sample_ready);
    end
    #2 nrst = 1'b0;
    #1;
    checks++;
    if (all_outputs() !== '0) begin
      errors++;
      $display("FAIL midrun_reset_outputs: got %h expected 0", all_outputs());
    end
    @(negedge clk);
    nrst = 1'b1;
    base_q = upd_q.size();
    inference_valid = 1'b1;
    class_inference = 5'd20;
    encoding_done = 1'b1;
    class_gen_done = 1'b1;
    @(negedge clk);
    inference_valid = 1'b0;
    encoding_done = 1'b0;
    class_gen_done = 1'b0;
    @(negedge clk);
    checks++;
    if (all_outputs() !== '0 || upd_q.size() != base_q) begin
      errors++;
      $display("FAIL stray_after_reset: outputs=%h updates=%0d expected 0/%0d",
               all_outputs(), upd_q.size(), base_q);
    end
  endtask

  initial begin
    nrst = 1'b0; en = 1'b1; start = 1'b0; mode = 2'b00; num_epochs = '0;
    sample_valid = 1'b0; sample_label = '0; sample_last = 1'b0;
    encoding_done = 1'b0; inference_valid = 1'b0; class_inference = '0;
    class_gen_done = 1'b0;

    test_reset();
    test_reserved_mode();
    test_train_test();
    test_retrain();
    test_early_exit();
    test_saturation();
    test_random();
    test_enable_hold();
    test_reset_midrun();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule
